// File: rtl/hall_call_sched.sv
// Hall-call scheduler: per-direction pending bitmaps, SCAN-ordered dispatch over valid/ready.
// Optional dropped-request counter enabled by defining HALL_CALL_STATS_EN.
module hall_call_sched #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_dir,
  input  logic               flush,
  input  logic [FLOOR_W-1:0] cur_floor,
  output logic               dout_valid,
  output logic [FLOOR_W-1:0] dout_floor,
  output logic               dout_dir,
  input  logic               dout_ready,
  output logic               q_empty,
  output logic [CNT_W-1:0]   pend_cnt,
  output logic [7:0]         drop_cnt
);

  typedef enum logic [0:0] {SCAN_UP = 1'b0, SCAN_DOWN = 1'b1} scan_t;

  scan_t              scan;
  scan_t              scan_next;
  logic [FLOORS-1:0]  up_pend;
  logic [FLOORS-1:0]  dn_pend;
  logic [FLOORS-1:0]  up_next;
  logic [FLOORS-1:0]  dn_next;
  logic [FLOORS-1:0]  req_hot;
  logic [FLOORS-1:0]  sel_hot;
  logic               dv_next;
  logic [FLOOR_W-1:0] df_next;
  logic               dd_next;
  logic               found;
  logic [FLOOR_W-1:0] sel_floor;
  logic               sel_dir;
  logic               load;
  logic               invalid;
  logic               dup;
  logic               accept;
  int                 cf;
  int                 cnt;

  // Sweep selection: first pending call in SCAN order from the clamped car floor
  always_comb begin
    logic hit;
    cf        = (int'(cur_floor) >= FLOORS) ? FLOORS - 1 : int'(cur_floor);
    found     = 1'b0;
    sel_floor = '0;
    sel_dir   = 1'b0;
    hit       = 1'b0;
    case (scan)
      SCAN_UP: begin
        for (int i = 0; i < FLOORS; i++) begin
          hit = !found && (i >= cf) && up_pend[i];
          sel_floor = hit ? FLOOR_W'(i) : sel_floor;
          sel_dir   = hit ? 1'b0 : sel_dir;
          found     = found | hit;
        end
        for (int i = FLOORS - 1; i >= 0; i--) begin
          hit = !found && dn_pend[i];
          sel_floor = hit ? FLOOR_W'(i) : sel_floor;
          sel_dir   = hit ? 1'b1 : sel_dir;
          found     = found | hit;
        end
        for (int i = 0; i < FLOORS; i++) begin
          hit = !found && (i < cf) && up_pend[i];
          sel_floor = hit ? FLOOR_W'(i) : sel_floor;
          sel_dir   = hit ? 1'b0 : sel_dir;
          found     = found | hit;
        end
      end
      SCAN_DOWN: begin
        for (int i = FLOORS - 1; i >= 0; i--) begin
          hit = !found && (i <= cf) && dn_pend[i];
          sel_floor = hit ? FLOOR_W'(i) : sel_floor;
          sel_dir   = hit ? 1'b1 : sel_dir;
          found     = found | hit;
        end
        for (int i = 0; i < FLOORS; i++) begin
          hit = !found && up_pend[i];
          sel_floor = hit ? FLOOR_W'(i) : sel_floor;
          sel_dir   = hit ? 1'b0 : sel_dir;
          found     = found | hit;
        end
        for (int i = FLOORS - 1; i >= 0; i--) begin
          hit = !found && (i > cf) && dn_pend[i];
          sel_floor = hit ? FLOOR_W'(i) : sel_floor;
          sel_dir   = hit ? 1'b1 : sel_dir;
          found     = found | hit;
        end
      end
      default: begin
        found     = 1'b0;
        sel_floor = '0;
        sel_dir   = 1'b0;
      end
    endcase
  end

  // One-hot decodes of request and selected floor, occupancy count
  always_comb begin
    req_hot = '0;
    sel_hot = '0;
    cnt     = 0;
    for (int i = 0; i < FLOORS; i++) begin
      req_hot[i] = (int'(req_floor) == i);
      sel_hot[i] = (int'(sel_floor) == i);
      cnt        = cnt + int'(up_pend[i]) + int'(dn_pend[i]);
    end
  end

  assign pend_cnt = CNT_W'(cnt);
  assign q_empty  = (up_pend == '0) && (dn_pend == '0);

  assign load    = found && (!dout_valid || dout_ready) && !flush;
  assign invalid = (int'(req_floor) >= FLOORS)
                 || (!req_dir && (int'(req_floor) == FLOORS - 1))
                 || (req_dir && (req_floor == '0));
  // A call already in a bitmap, sitting in the slot, or loading now is a duplicate
  assign dup     = (|(req_hot & (req_dir ? dn_pend : up_pend)))
                 || (dout_valid && (dout_floor == req_floor) && (dout_dir == req_dir))
                 || (load && (sel_floor == req_floor) && (sel_dir == req_dir));
  assign accept  = req_valid && !flush && !invalid && !dup;

  // Next state of pending bitmaps and output slot
  always_comb begin
    up_next = up_pend;
    dn_next = dn_pend;
    dv_next = dout_valid;
    df_next = dout_floor;
    dd_next = dout_dir;
    if (flush) begin
      up_next = '0;
      dn_next = '0;
      dv_next = 1'b0;
    end else begin
      if (load) begin
        dv_next = 1'b1;
        df_next = sel_floor;
        dd_next = sel_dir;
        up_next = sel_dir ? up_pend : (up_pend & ~sel_hot);
        dn_next = sel_dir ? (dn_pend & ~sel_hot) : dn_pend;
      end else if (dout_valid && dout_ready) begin
        dv_next = 1'b0;
      end else begin
        dv_next = dout_valid;
      end
      if (accept) begin
        up_next = req_dir ? up_next : (up_next | req_hot);
        dn_next = req_dir ? (dn_next | req_hot) : dn_next;
      end else begin
        up_next = up_next;
      end
    end
  end

  // Scan direction follows the direction of each loaded call
  always_comb begin
    scan_next = scan;
    case (scan)
      SCAN_UP, SCAN_DOWN: scan_next = load ? (sel_dir ? SCAN_DOWN : SCAN_UP) : scan;
      default:            scan_next = SCAN_UP;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan       <= SCAN_UP;
      up_pend    <= '0;
      dn_pend    <= '0;
      dout_valid <= 1'b0;
      dout_floor <= '0;
      dout_dir   <= 1'b0;
    end else begin
      scan       <= scan_next;
      up_pend    <= up_next;
      dn_pend    <= dn_next;
      dout_valid <= dv_next;
      dout_floor <= df_next;
      dout_dir   <= dd_next;
    end
  end

`ifdef HALL_CALL_STATS_EN
  logic       dropped;
  logic [7:0] drop_q;

  assign dropped  = req_valid && !flush && (invalid || dup);
  assign drop_cnt = drop_q;

  // Saturating drop counter; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else if (dropped && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end else begin
      drop_q <= drop_q;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
